// File: rtl/alu_operand_pkg.sv
// Shared types and constants for the ALU operand-selection stage.
// Select codes mirror the decoder's 2-bit alu_a_src / alu_b_src fields.
package alu_operand_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int FOUR_VAL   = 4;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_ZERO = 2'b10,
        A_RSV  = 2'b11
    } a_src_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'b00,
        B_IMM  = 2'b01,
        B_FOUR = 2'b10,
        B_RSV  = 2'b11
    } b_src_e;

endpackage

// File: rtl/alu_operand_stage_fwd_resolve.sv
// Priority forwarding for one source register: source 0 (youngest) wins,
// and x0 always reads as zero with no hit.
module fwd_resolve #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int FWD_PORTS = 2
) (
    input  logic [REG_AW-1:0]           addr,
    input  logic [XLEN-1:0]             ru_data,
    input  logic [FWD_PORTS-1:0]        fwd_valid,
    input  logic [FWD_PORTS*REG_AW-1:0] fwd_rd,
    input  logic [FWD_PORTS*XLEN-1:0]   fwd_data,
    output logic [XLEN-1:0]             value,
    output logic                        hit
);

    always_comb begin
        // NOTE: outputs get a default before any conditional path so no latch is inferred.
        value = ru_data;
        hit   = 1'b0;
        // Walk from oldest to youngest so the lowest matching index is applied last.
        for (int i = FWD_PORTS - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_rd[i*REG_AW +: REG_AW] == addr)) begin
                value = fwd_data[i*XLEN +: XLEN];
                hit   = 1'b1;
            end
        end
        if (addr == '0) begin
            value = '0;
            hit   = 1'b0;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand-selection stage: forwards rs1/rs2, selects ALU A/B and store
// data, and holds the result in a one-entry valid/ready slot with stall and flush.
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int FWD_PORTS = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [XLEN-1:0]             pc,
    input  logic [REG_AW-1:0]           rs1_addr,
    input  logic [REG_AW-1:0]           rs2_addr,
    input  logic [XLEN-1:0]             ru_rs1,
    input  logic [XLEN-1:0]             ru_rs2,
    input  logic [XLEN-1:0]             imm,
    input  logic [1:0]                  alu_a_src,
    input  logic [1:0]                  alu_b_src,
    input  logic [FWD_PORTS-1:0]        fwd_valid,
    input  logic [FWD_PORTS*REG_AW-1:0] fwd_rd,
    input  logic [FWD_PORTS*XLEN-1:0]   fwd_data,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             alu_a,
    output logic [XLEN-1:0]             alu_b,
    output logic [XLEN-1:0]             store_data,
    output logic [1:0]                  fwd_hit,
    output logic                        illegal_sel
);

    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            rs1_hit, rs2_hit;

    fwd_resolve #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_PORTS(FWD_PORTS)) u_rs1_fwd (
        .addr      (rs1_addr),
        .ru_data   (ru_rs1),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .value     (rs1_val),
        .hit       (rs1_hit)
    );

    fwd_resolve #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_PORTS(FWD_PORTS)) u_rs2_fwd (
        .addr      (rs2_addr),
        .ru_data   (ru_rs2),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .value     (rs2_val),
        .hit       (rs2_hit)
    );

    a_src_e a_sel;
    b_src_e b_sel;
    assign a_sel = a_src_e'(alu_a_src);
    assign b_sel = b_src_e'(alu_b_src);

    logic [XLEN-1:0] a_mux, b_mux;
    logic [1:0]      hit_mux;
    logic            ill_mux;

    always_comb begin
        a_mux = '0;
        b_mux = '0;
        unique case (a_sel)
            A_RS1:  a_mux = rs1_val;
            A_PC:   a_mux = pc;
            A_ZERO: a_mux = '0;
            A_RSV:  a_mux = '0;
        endcase
        unique case (b_sel)
            B_RS2:  b_mux = rs2_val;
            B_IMM:  b_mux = imm;
            B_FOUR: b_mux = XLEN'(FOUR_VAL);
            B_RSV:  b_mux = '0;
        endcase
        // rs2 always feeds store data, so its hit is reported regardless of alu_b_src.
        hit_mux = {rs2_hit, rs1_hit && (a_sel == A_RS1)};
        ill_mux = (a_sel == A_RSV) || (b_sel == B_RSV);
    end

    logic            valid_q, valid_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [XLEN-1:0] store_q, store_d;
    logic [1:0]      hit_q, hit_d;
    logic            ill_q, ill_d;
    logic            capture;

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        store_d = store_q;
        hit_d   = hit_q;
        ill_d   = ill_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            alu_a_d = a_mux;
            alu_b_d = b_mux;
            store_d = rs2_val;
            hit_d   = hit_mux;
            ill_d   = ill_mux;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the datapath registers are reset too, since every output has a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            store_q <= '0;
            hit_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            valid_q <= valid_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            store_q <= store_d;
            hit_q   <= hit_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid   = valid_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign store_data  = store_q;
    assign fwd_hit     = hit_q;
    assign illegal_sel = ill_q;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-selection stage for the pipelined RV32I core. Successor to the single-cycle ALU-A mux.
- Resolves both ALU operands (A and B) and the store data from register-file reads, PC, immediate or constants.
- Applies a parametrised number of forwarding sources, with x0 treated as hard zero.
- Registers the result into a one-entry ID/EX slot with valid/ready handshake, stall and flush.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-address width.
- FWD_PORTS, 2, number of forwarding sources; index 0 = youngest (EX/MEM), highest priority.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage can accept this cycle.
- pc  input  XLEN  instruction PC.
- rs1_addr, rs2_addr  input  REG_AW each  source register indices.
- ru_rs1, ru_rs2  input  XLEN each  register-file read data.
- imm  input  XLEN  sign-extended immediate.
- alu_a_src  input  2  00 = rs1, 01 = pc, 10 = zero, 11 = reserved.
- alu_b_src  input  2  00 = rs2, 01 = imm, 10 = constant 4, 11 = reserved.
- fwd_valid  input  FWD_PORTS  forwarding source i writes a register.
- fwd_rd  input  FWD_PORTS*REG_AW  destination index per source, packed, source i at [i*REG_AW +: REG_AW].
- fwd_data  input  FWD_PORTS*XLEN  result per source, packed the same way.
- flush  input  1  squash the held entry and any same-cycle capture.
- out_valid  output  1  registered operands valid.
- out_ready  input  1  EX consumes this cycle.
- alu_a, alu_b  output  XLEN each  registered operands.
- store_data  output  XLEN  registered forwarded rs2 value.
- fwd_hit  output  2  registered; bit 0 = rs1 forwarded, bit 1 = rs2 forwarded.
- illegal_sel  output  1  registered; a reserved src code was captured.

Behaviour:
- Reset (async assert, sync release): out_valid, alu_a, alu_b, store_data, fwd_hit and illegal_sel all go to 0.
- in_ready = !out_valid || out_ready. Combinational; no dependence on in_valid.
- Capture when in_valid && in_ready && !flush. Outputs update on the next edge, so latency is 1 cycle.
- Operand resolve for rsX (combinational, before the register):
  - If addr == 0, value = 0 and no hit, even if a forwarding source names x0.
  - Else take the lowest i with fwd_valid[i] && fwd_rd[i] == addr. Value = fwd_data[i], hit = 1.
  - Else value = ru_rsX, hit = 0.
- Selection: A from alu_a_src, B from alu_b_src, using the resolved rs1/rs2. store_data is always the resolved rs2, whatever alu_b_src says.
- Reserved code 11 on either select: that operand = 0, and illegal_sel = 1 is captured with the entry.
- fwd_hit records hits only for operands actually selected. rs2 used only as store data still sets bit 1.
- Stall: when out_valid && !out_ready, every output holds bit-stable. Inputs, including forwarding, are ignored.
- Consume without refill (out_ready && out_valid && !in_valid): out_valid -> 0 next cycle. Data outputs may hold stale values.
- Simultaneous consume and capture gives back-to-back throughput of 1 per cycle.
- flush = 1: out_valid -> 0 next cycle regardless of out_ready/in_valid. No capture that cycle. Flush has priority over stall and capture.
- Reset mid-stall: the entry is dropped immediately and outputs go to their reset values.

Decomposition:
- Package alu_operand_pkg holds:
  - enum a_src_e {A_RS1, A_PC, A_ZERO, A_RSV}
  - enum b_src_e {B_RS2, B_IMM, B_FOUR, B_RSV}
  - constant XLEN_DEF = 32, REG_AW_DEF = 5, and the constant-4 value.
- Sub-module fwd_resolve: combinational priority forwarding for one source register, parameters XLEN/REG_AW/FWD_PORTS, outputs value and hit. Instantiated twice (rs1, rs2). The top holds the select muxes and the ID/EX register.

Test Plan:
- Reset, then rs1_addr = 3, ru_rs1 = 0x00000002, pc = 0x00000001, a_src = 00, b_src = 01, imm = 0x10, in_valid = 1, out_ready = 1, no fwd. One cycle later: alu_a = 0x2, alu_b = 0x10, out_valid = 1, fwd_hit = 00.
- a_src = 01, pc = 0x00000003, b_src = 10 -> alu_a = 0x3, alu_b = 0x4.
- rs1 = 5, rs2 = 5. fwd_valid = 11, fwd_rd[0] = fwd_rd[1] = 5, fwd_data[0] = 0xAAAA0000, fwd_data[1] = 0xBBBB0000, b_src = 00 -> alu_a = alu_b = store_data = 0xAAAA0000, fwd_hit = 11. Repeat with rs1 = 0 and fwd_rd[0] = 0, fwd_data[0] = 0xDEAD -> alu_a = 0, fwd_hit[0] = 0.
- Capture 0x11, then hold out_ready = 0 for 3 cycles while changing inputs -> in_ready = 0, alu_a stays 0x11. On release, the next entry follows back-to-back with no bubble.
- Stalled entry valid, assert flush with in_valid = 1 -> out_valid = 0 next cycle, new entry not captured. Assert rst_n = 0 mid-stall -> all outputs 0 immediately.
- a_src = 11, ru_rs1 = 0x55 -> alu_a = 0, illegal_sel = 1 for that entry only. The next legal entry clears it.
